// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Optional build macro RV_MULDIV_FAST_MUL_EN: single-cycle combinational MUL* path.
module rv_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op_in,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] b_q;
  logic        neg_q, neg_r, pend;

  // Operand decode for the incoming request
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, fast_hit, short_hit, accept;
  logic [31:0] fast_val, short_val;

  assign a_signed = op_in inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
  assign b_signed = op_in inside {3'd0, 3'd1, 3'd4, 3'd6};
  assign a_neg    = a_signed & rs1[31];
  assign b_neg    = b_signed & rs2[31];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;
  assign div_zero = op_in[2] && (rs2 == 32'd0);
  assign div_ovf  = (op_in == 3'd4 || op_in == 3'd6) &&
                    (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

`ifdef RV_MULDIV_FAST_MUL_EN
  logic signed [63:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{32{a_neg}}, rs1};
  assign fast_b    = {{32{b_neg}}, rs2};
  assign fast_prod = fast_a * fast_b;
  assign fast_hit  = !op_in[2];
  assign fast_val  = (op_in == 3'd0) ? fast_prod[31:0] : fast_prod[63:32];
`else
  assign fast_hit  = 1'b0;
  assign fast_val  = 32'd0;
`endif

  assign short_hit = div_zero | div_ovf | fast_hit;
  always_comb begin
    if (div_zero)     short_val = op_in[1] ? rs1 : 32'hFFFF_FFFF;
    else if (div_ovf) short_val = op_in[1] ? 32'd0 : 32'h8000_0000;
    else              short_val = fast_val;
  end

  // A short-circuit op spends one idle-looking cycle in IDLE with pend set
  assign accept = start && (state == IDLE || state == DONE) && !pend;

  // One iteration of each algorithm on the shared 64-bit accumulator
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_step, div_step;

  assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, b_q};
  assign mul_step  = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_step  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0],  acc[30:0], 1'b1};

  logic [63:0] prod;
  logic [31:0] quo, rem, fix_res;

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[31:0] : acc[31:0];
  assign rem  = neg_r ? -acc[63:32] : acc[63:32];

  always_comb begin
    case (op)
      3'd0:          fix_res = prod[31:0];
      3'd4, 3'd5:    fix_res = quo;
      3'd6, 3'd7:    fix_res = rem;
      default:       fix_res = prod[63:32];
    endcase
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = pend ? DONE : IDLE;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (accept) state_nxt = short_hit ? IDLE : RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= 1'b0;
      op    <= 3'd0;
      cnt   <= 5'd0;
      acc   <= 64'd0;
      b_q   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rd    <= 32'd0;
    end else begin
      state <= state_nxt;
      pend  <= accept & short_hit;
      if (accept) begin
        op    <= op_in;
        cnt   <= 5'd0;
        b_q   <= b_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        acc   <= short_hit ? {32'd0, short_val} : {32'd0, a_mag};
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        acc <= op[2] ? div_step : mul_step;
      end
      if (state == FIX) rd <= fix_res;
      else if (pend)    rd <= acc[31:0];
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed self-checking bench for rv_muldiv; honours RV_MULDIV_FAST_MUL_EN for MUL* latency.
module tb_rv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_in = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        busy, done;
  logic [31:0] rd;

  int checks = 0;
  int failures = 0;

  // Latency is counted in rising edges after the accepting edge.
  localparam int LAT_LONG  = 33;
  localparam int LAT_SHORT = 1;
`ifdef RV_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = LAT_SHORT;
`else
  localparam int LAT_MUL = LAT_LONG;
`endif

  rv_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_in (op_in),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; lat counts edges since entry, bs records any busy seen.
  task automatic wait_done(input int lat0, output int lat, output bit bs);
    lat = lat0;
    bs  = busy;
    while (!done && lat < 60) begin
      tick();
      lat++;
      bs |= busy;
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_in = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit bs;
    issue(o, a, b);
    wait_done(0, lat, bs);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rd"}, rd, exp);
    check({tag, "_busy"}, {31'd0, bs}, {31'd0, exp_lat > 1});
  endtask

  initial begin
    int lat;
    bit bs;
    bit done_seen;

    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd", rd, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("mulh_neg",  3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, LAT_MUL);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    do_op("mul_neg",   3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, LAT_MUL);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);
    do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL);
    do_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);

    do_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_LONG);
    do_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_LONG);
    do_op("divu",      3'd5, 32'd100, 32'd7, 32'd14, LAT_LONG);
    do_op("remu",      3'd7, 32'd100, 32'd7, 32'd2, LAT_LONG);
    do_op("rem_negb",  3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_LONG);
    do_op("div_negb",  3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_LONG);

    do_op("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SHORT);
    do_op("rem_zero",  3'd6, 32'd5, 32'd0, 32'd5, LAT_SHORT);
    do_op("div_zero",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SHORT);
    do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SHORT);
    do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SHORT);

    // Start while busy must be ignored
    issue(3'd5, 32'hFFFF_FFFF, 32'h10);
    repeat (5) tick();
    issue(3'd5, 32'd5, 32'd0);
    wait_done(6, lat, bs);
    check("ign_lat", lat, LAT_LONG);
    check("ign_rd", rd, 32'h0FFF_FFFF);

    // Back-to-back: start issued during the DONE cycle
    do_op("b2b_first", 3'd7, 32'd100, 32'd7, 32'd2, LAT_LONG);
    issue(3'd5, 32'd100, 32'd7);
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    check("b2b_busy_rise", {31'd0, busy}, 32'd1);
    wait_done(0, lat, bs);
    check("b2b_lat", lat, LAT_LONG);
    check("b2b_rd", rd, 32'd14);

    // Reset in the middle of RUN aborts with no done
    tick();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (10) tick();
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rd", rd, 32'd0);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_seen |= done;
      tick();
    end
    check("mid_rst_nodone", {31'd0, done_seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
